// File: rtl/ipsxe_floating_point_apm_addshare_arb_v1_0_pkg.sv
// Shared helpers for the APM add-share arbiter slice.
// Width helpers keep tag and slot sizing in one place.
package ipsxe_floating_point_apm_addshare_arb_v1_0_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int tag_width(input int id_w);
    return id_w + 1;
  endfunction

  function automatic int slot_width(input int a_w);
    return a_w + 1;
  endfunction

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_A_WIDTH = 9;
  localparam int TAG_W  = tag_width(clog2(DEF_NUM_REQ));
  localparam int SLOT_W = slot_width(DEF_A_WIDTH);

endpackage

// File: rtl/ipsxe_floating_point_rr_arb_v1_0.sv
// Combinational round-robin arbiter.
// Search starts at ptr; next pointer is one past the winner.
module ipsxe_floating_point_rr_arb_v1_0
  import ipsxe_floating_point_apm_addshare_arb_v1_0_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] nxt_ptr
);

  logic [PW-1:0] idx;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant   = '0;
    nxt_ptr = ptr;
    idx     = '0;
    for (int o = N - 1; o >= 0; o--) begin
      idx = PW'((int'(ptr) + o) % N);
      if (eligible[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        nxt_ptr    = PW'((int'(idx) + 1) % N);
      end
    end
  end

endmodule

// File: rtl/ipsxe_floating_point_apm_addshare_arb_v1_0.sv
// Time-shares one APM post-adder (a0_hi + signed cin)
// between NUM_REQ requesters with per-requester result slots.
module ipsxe_floating_point_apm_addshare_arb_v1_0
  import ipsxe_floating_point_apm_addshare_arb_v1_0_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 9,
  parameter int C_WIDTH = 2,
  parameter int APM_LAT = 1,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]     i_req_a0_hi,
  input  logic [NUM_REQ*C_WIDTH-1:0]     i_req_cin,
  output logic [A_WIDTH:0]               o_apm_z,
  output logic [A_WIDTH:0]               o_apm_x,
  input  logic [A_WIDTH:0]               i_apm_p,
  output logic [NUM_REQ-1:0]             o_rsp_valid,
  input  logic [NUM_REQ-1:0]             i_rsp_ready,
  output logic [NUM_REQ*(A_WIDTH+1)-1:0] o_rsp_data,
  output logic                           o_busy
);

  localparam int P_W = slot_width(A_WIDTH);
  localparam int TW  = tag_width(ID_W);

  logic [NUM_REQ-1:0] outstanding;
  logic [NUM_REQ-1:0] rsp_v;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] hs;
  logic [NUM_REQ-1:0] cap;
  logic [NUM_REQ-1:0] out_nxt;
  logic [NUM_REQ-1:0] rsp_nxt;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    nxt_ptr;
  logic [ID_W-1:0]    gid;
  logic [TW-1:0]      g_tag;
  logic [TW-1:0]      al_tag;
  logic [P_W-1:0]     slot [NUM_REQ];

  assign eligible = i_req_valid & ~outstanding & {NUM_REQ{i_rst_n}};

  ipsxe_floating_point_rr_arb_v1_0 #(
    .N  (NUM_REQ),
    .PW (ID_W)
  ) u_arb (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant),
    .nxt_ptr  (nxt_ptr)
  );

  assign o_req_ready = grant;

  always_comb begin
    o_apm_z = '0;
    o_apm_x = '0;
    gid     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gid     = ID_W'(i);
        o_apm_z = {1'b0, i_req_a0_hi[i*A_WIDTH +: A_WIDTH]};
        o_apm_x = {{(P_W-C_WIDTH){i_req_cin[i*C_WIDTH+C_WIDTH-1]}},
                   i_req_cin[i*C_WIDTH +: C_WIDTH]};
      end
    end
  end

  assign g_tag = {|grant, gid};

  generate
    if (APM_LAT == 0) begin : g_nopipe
      assign al_tag = g_tag;
    end else begin : g_pipe
      logic [TW-1:0] pipe [APM_LAT];
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int k = 0; k < APM_LAT; k++) pipe[k] <= '0;
        end else begin
          pipe[0] <= g_tag;
          for (int k = 1; k < APM_LAT; k++) pipe[k] <= pipe[k-1];
        end
      end
      assign al_tag = pipe[APM_LAT-1];
    end
  endgenerate

  assign hs      = rsp_v & i_rsp_ready;
  assign cap     = al_tag[TW-1] ?
                   (NUM_REQ'(1) << al_tag[ID_W-1:0]) : '0;
  assign out_nxt = (outstanding | grant) & ~hs;
  assign rsp_nxt = (rsp_v & ~hs) | cap;

  // In-flight tags are always covered by their outstanding bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr         <= '0;
      outstanding <= '0;
      rsp_v       <= '0;
      o_busy      <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) slot[i] <= '0;
    end else begin
      ptr         <= nxt_ptr;
      outstanding <= out_nxt;
      rsp_v       <= rsp_nxt;
      o_busy      <= |out_nxt | |rsp_nxt;
      for (int i = 0; i < NUM_REQ; i++)
        if (cap[i]) slot[i] <= i_apm_p;
    end
  end

  always @(posedge i_clk) begin
    if (i_rst_n && al_tag[TW-1])
      assert (!rsp_v[al_tag[ID_W-1:0]]);
  end

  assign o_rsp_valid = rsp_v;

  always_comb begin
    o_rsp_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      o_rsp_data[i*P_W +: P_W] = slot[i];
  end

endmodule

// File: doc/ipsxe_floating_point_apm_addshare_arb_v1_0.md
Name: ipsxe_floating_point_apm_addshare_arb_v1_0

Overview:
Round-robin arbiter and sequencer that time-shares one GTP_APM_E2 post-adder instance between NUM_REQ requesters. The shared instance computes a0_hi + sign-extended carry, which is the same operation the a0hi_plus_cin1 primitive performs. The block grants at most one operation per cycle and tracks the APM's fixed pipeline latency with a tag shift register. It returns each result to a per-requester holding slot that uses a valid/ready handshake. It sits in the invsqrt/reciprocal datapath, between the iteration stages and a single APM.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
A_WIDTH, 9, width of the a0_hi operand.
C_WIDTH, 2, width of the signed carry operand.
APM_LAT, 1, APM input-to-P latency in cycles (0..2); it must match the X_REG/Z_REG/P_REG settings of the shared APM.
ID_W, clog2(NUM_REQ), requester tag width (derived).

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  NUM_REQ  per-requester operation request
o_req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid&ready
i_req_a0_hi  in  NUM_REQ*A_WIDTH  packed a0_hi operands, requester 0 in the LSBs
i_req_cin  in  NUM_REQ*C_WIDTH  packed signed carry operands
o_apm_z  out  A_WIDTH+1  to APM Z: {1'b0, a0_hi}
o_apm_x  out  A_WIDTH+1  to APM X: cin sign-extended
i_apm_p  in  A_WIDTH+1  APM P result
o_rsp_valid  out  NUM_REQ  result slot full
i_rsp_ready  in  NUM_REQ  requester accepts the result
o_rsp_data  out  NUM_REQ*(A_WIDTH+1)  packed result slots
o_busy  out  1  any operation in flight or any slot full

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - o_req_ready, o_rsp_valid, tag pipe valids, outstanding flags and o_busy all go to 0.
  - The round-robin pointer goes to 0.
  - o_apm_z, o_apm_x and o_rsp_data go to 0.
- Reset mid-operation: in-flight tags are discarded and no response is issued afterwards.
- Eligibility: requester i is eligible when i_req_valid[i]=1 and outstanding[i]=0.
- Credit rule: each requester has at most 1 operation outstanding.
  - outstanding[i] is set on grant.
  - It is cleared on the rsp handshake (o_rsp_valid[i]&i_rsp_ready[i]).
  - The clear takes effect the next cycle, so a requester is not eligible in the cycle its response is accepted.
- Arbitration is combinational round-robin.
  - Search starts at the pointer and wraps modulo NUM_REQ.
  - o_req_ready is one-hot or zero.
  - On a grant to k, the pointer becomes (k+1) mod NUM_REQ; with no grant the pointer holds.
- Operand drive: o_apm_z/o_apm_x are combinational muxes of the granted requester's operands. When there is no grant they are driven to 0.
- Tag pipe: depth APM_LAT, each entry {valid, id}, shifted every cycle.
  - The entry at stage APM_LAT is aligned with i_apm_p.
  - For APM_LAT=0 the grant itself is the aligned entry, and i_apm_p is used in the same cycle.
- Result capture: when the aligned entry is valid, i_apm_p is written to slot[id] and o_rsp_valid[id] is set at the next clock edge.
  - The slot cannot already be full; the credit rule guarantees this.
  - If it is full, a simulation assertion fires.
- Response: o_rsp_valid[i] holds and o_rsp_data is stable until i_rsp_ready[i]. A handshake clears valid at the next edge.
- Throughput: 1 op/cycle across requesters. Per-requester rate is 1 op per (APM_LAT+2) cycles minimum.
- Latency: grant to o_rsp_valid = APM_LAT+1 cycles.
- Arithmetic: the result is the modular A_WIDTH+1-bit sum from the APM. Negative cin gives a0_hi-1 or a0_hi-2.
- o_busy is registered: OR of tag valids, outstanding flags and o_rsp_valid.

Decomposition:
- A shared package holds:
  - the clog2 function;
  - the tag record width localparam (ID_W+1);
  - the slot width localparam A_WIDTH+1.
- One sub-module: ipsxe_floating_point_rr_arb_v1_0.
  - Parameter N.
  - Inputs: eligible vector and pointer.
  - Output: one-hot grant and next pointer.
  - It is combinational and reused elsewhere in the codebase.
- The APM itself is instantiated by the parent, not by this block.

Test Plan:
- Reset mid-flight:
  - Stimulus: APM_LAT=1; requester 2 sends a0_hi=9'h0FF, cin=2'b01; reset is asserted 1 cycle after the grant.
  - Required response: no rsp_valid ever appears; pointer=0; all outputs are 0 after reset.
- Single op:
  - Stimulus: APM_LAT=1; requester 0 sends a0_hi=9'h1FF, cin=2'b01; i_rsp_ready=1.
  - Required response: o_apm_z=10'h1FF and o_apm_x=10'h001 in the grant cycle; o_rsp_valid[0] is high 2 cycles later with data 10'h200.
- Negative carry:
  - Stimulus: a0_hi=9'h005, cin=2'b11.
  - Required response: o_apm_x=10'h3FF; result 10'h004.
- Round-robin fairness:
  - Stimulus: all 4 requesters hold valid continuously; rsp_ready=1.
  - Required response: grants follow the order 0,1,2,3 in consecutive cycles; requester 0 is granted again only after its response is accepted.
- Back-pressure:
  - Stimulus: requester 1 holds i_rsp_ready=0 for 10 cycles.
  - Required response: o_rsp_data[1] is stable for those 10 cycles; requester 1 receives no grant during that time; other requesters continue uninterrupted.
- Simultaneous handshake:
  - Stimulus: in the same cycle, rsp[3] is accepted while requester 3 has a new valid.
  - Required response: no grant to requester 3 that cycle; requester 3 is granted the next cycle if the pointer allows.
